// File: rtl/alu_pkg.sv
// Shared definitions for users of the 8-bit combinational alu.
//   - 3-bit opcode encoding (ADD..XOR) as driven on the alu Opcode input.
//   - State enum for alu_op_sequencer.
//   - is_arith(): true for the ops whose carry/borrow chain spans both bytes.
package alu_pkg;

  localparam logic [2:0] OpAdd  = 3'b000;
  localparam logic [2:0] OpSub  = 3'b001;
  localparam logic [2:0] OpComp = 3'b010;
  localparam logic [2:0] OpAnd  = 3'b011;
  localparam logic [2:0] OpOr   = 3'b100;
  localparam logic [2:0] OpNand = 3'b101;
  localparam logic [2:0] OpNor  = 3'b110;
  localparam logic [2:0] OpXor  = 3'b111;

  typedef enum logic [2:0] {
    StIdle,
    StLo,
    StHi,
    StFix,
    StDone
  } seq_state_e;

  function automatic logic is_arith(input logic [2:0] op);
    return (op == OpAdd) || (op == OpSub);
  endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: runs a 16-bit two-operand command through an external 8-bit
// combinational alu as a low-byte pass, a high-byte pass and, when an ADD/SUB
// low byte carries or borrows, a fix-up pass that adds/subtracts 1 to the high byte.
//
// Ports
//   clk, rst_n                    clock (rising edge), async active-low reset
//   cmd_valid_i / cmd_ready_o     command handshake
//   cmd_op_i[2:0]                 opcode (alu encoding)
//   cmd_a_i[15:0], cmd_b_i[15:0]  operands (b ignored for COMP)
//   alu_opcode_o, alu_op1_o, alu_op2_o   registered drive to the alu
//   alu_res_i, alu_c_i, alu_ac_i         alu outputs sampled after each pass
//   rsp_valid_o / rsp_ready_i     response handshake
//   rsp_result_o[15:0]            result
//   rsp_c_o, rsp_ac_o, rsp_z_o, rsp_s_o  carry/borrow, nibble carry, zero, sign
//   rsp_ovf_o                     signed overflow (only with ALU_SEQ_OVF_EN)
//
// Build option: define ALU_SEQ_OVF_EN to add rsp_ovf_o.
// Response outputs read as zero whenever rsp_valid_o is low.
module alu_op_sequencer
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [2:0]  cmd_op_i,
  input  logic [15:0] cmd_a_i,
  input  logic [15:0] cmd_b_i,
  output logic [2:0]  alu_opcode_o,
  output logic [7:0]  alu_op1_o,
  output logic [7:0]  alu_op2_o,
  input  logic [7:0]  alu_res_i,
  input  logic        alu_c_i,
  input  logic        alu_ac_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [15:0] rsp_result_o,
  output logic        rsp_c_o,
  output logic        rsp_ac_o,
  output logic        rsp_z_o,
  output logic        rsp_s_o
`ifdef ALU_SEQ_OVF_EN
  ,
  output logic        rsp_ovf_o
`endif
);

  seq_state_e  state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [7:0]  a_hi_q, a_hi_d;
  logic [7:0]  b_hi_q, b_hi_d;
  logic [15:0] res_q, res_d;
  logic        c_lo_q, c_lo_d;
  logic        c_hi_q, c_hi_d;
  logic        ac_q, ac_d;
  logic [2:0]  alu_opcode_q, alu_opcode_d;
  logic [7:0]  alu_op1_q, alu_op1_d;
  logic [7:0]  alu_op2_q, alu_op2_d;

  logic need_fix;
  logic done;

  // Low byte carried (ADD) or borrowed (SUB): high byte must be bumped by 1.
  assign need_fix = is_arith(op_q) && c_lo_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cmd_valid_i) state_d = StLo;
      StLo:    state_d = StHi;
      StHi:    state_d = need_fix ? StFix : StDone;
      StFix:   state_d = StDone;
      StDone:  if (rsp_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: each state captures the pass that the alu has just
  // evaluated and sets up the operands for the following pass.
  always_comb begin
    op_d         = op_q;
    a_hi_d       = a_hi_q;
    b_hi_d       = b_hi_q;
    res_d        = res_q;
    c_lo_d       = c_lo_q;
    c_hi_d       = c_hi_q;
    ac_d         = ac_q;
    alu_opcode_d = alu_opcode_q;
    alu_op1_d    = alu_op1_q;
    alu_op2_d    = alu_op2_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          op_d         = cmd_op_i;
          a_hi_d       = cmd_a_i[15:8];
          b_hi_d       = cmd_b_i[15:8];
          alu_opcode_d = cmd_op_i;
          alu_op1_d    = cmd_a_i[7:0];
          alu_op2_d    = cmd_b_i[7:0];
        end
      end
      StLo: begin
        res_d[7:0] = alu_res_i;
        c_lo_d     = alu_c_i;
        ac_d       = alu_ac_i;
        alu_op1_d  = a_hi_q;
        alu_op2_d  = b_hi_q;
      end
      StHi: begin
        res_d[15:8] = alu_res_i;
        c_hi_d      = alu_c_i;
        if (need_fix) begin
          alu_op1_d = alu_res_i;
          alu_op2_d = 8'h01;
        end
      end
      StFix: begin
        res_d[15:8] = alu_res_i;
        // High pass and fix pass can never both carry/borrow, so OR is exact.
        c_hi_d      = c_hi_q | alu_c_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q         <= OpAdd;
      a_hi_q       <= '0;
      b_hi_q       <= '0;
      res_q        <= '0;
      c_lo_q       <= 1'b0;
      c_hi_q       <= 1'b0;
      ac_q         <= 1'b0;
      alu_opcode_q <= '0;
      alu_op1_q    <= '0;
      alu_op2_q    <= '0;
    end else begin
      op_q         <= op_d;
      a_hi_q       <= a_hi_d;
      b_hi_q       <= b_hi_d;
      res_q        <= res_d;
      c_lo_q       <= c_lo_d;
      c_hi_q       <= c_hi_d;
      ac_q         <= ac_d;
      alu_opcode_q <= alu_opcode_d;
      alu_op1_q    <= alu_op1_d;
      alu_op2_q    <= alu_op2_d;
    end
  end

  // Outputs
  always_comb begin
    done         = (state_q == StDone);
    cmd_ready_o  = (state_q == StIdle);
    rsp_valid_o  = done;
    alu_opcode_o = alu_opcode_q;
    alu_op1_o    = alu_op1_q;
    alu_op2_o    = alu_op2_q;
    rsp_result_o = done ? res_q : 16'h0000;
    rsp_c_o      = done && is_arith(op_q) && c_hi_q;
    rsp_ac_o     = done && is_arith(op_q) && ac_q;
    rsp_z_o      = done && (res_q == 16'h0000);
    rsp_s_o      = done && res_q[15];
  end

`ifdef ALU_SEQ_OVF_EN
  // Signed overflow from operand and result sign bits.
  always_comb begin
    rsp_ovf_o = 1'b0;
    if (done) begin
      if (op_q == OpAdd) begin
        rsp_ovf_o = (a_hi_q[7] == b_hi_q[7]) && (res_q[15] != a_hi_q[7]);
      end else if (op_q == OpSub) begin
        rsp_ovf_o = (a_hi_q[7] != b_hi_q[7]) && (res_q[15] != a_hi_q[7]);
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural 8-bit alu attached.
// Expected results come from a 16-bit reference model built from whole-word arithmetic.
module tb_alu_op_sequencer;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_a, cmd_b;
  logic [2:0]  alu_opcode;
  logic [7:0]  alu_op1, alu_op2;
  logic [7:0]  alu_res;
  logic        alu_c, alu_ac;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_c, rsp_ac, rsp_z, rsp_s;
`ifdef ALU_SEQ_OVF_EN
  logic        rsp_ovf;
`endif

  int checks = 0;
  int errors = 0;

  alu_op_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_op_i    (cmd_op),
    .cmd_a_i     (cmd_a),
    .cmd_b_i     (cmd_b),
    .alu_opcode_o(alu_opcode),
    .alu_op1_o   (alu_op1),
    .alu_op2_o   (alu_op2),
    .alu_res_i   (alu_res),
    .alu_c_i     (alu_c),
    .alu_ac_i    (alu_ac),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_result_o(rsp_result),
    .rsp_c_o     (rsp_c),
    .rsp_ac_o    (rsp_ac),
    .rsp_z_o     (rsp_z),
    .rsp_s_o     (rsp_s)
`ifdef ALU_SEQ_OVF_EN
    ,
    .rsp_ovf_o   (rsp_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 8-bit alu: C/AC are carry (ADD) or borrow (SUB) out of bit 7 / bit 3.
  logic [8:0] s9;
  logic [4:0] s5;
  always_comb begin
    s9      = '0;
    s5      = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_ac  = 1'b0;
    case (alu_opcode)
      3'd0: begin
        s9 = {1'b0, alu_op1} + {1'b0, alu_op2};
        s5 = {1'b0, alu_op1[3:0]} + {1'b0, alu_op2[3:0]};
        alu_res = s9[7:0]; alu_c = s9[8]; alu_ac = s5[4];
      end
      3'd1: begin
        s9 = {1'b0, alu_op1} - {1'b0, alu_op2};
        s5 = {1'b0, alu_op1[3:0]} - {1'b0, alu_op2[3:0]};
        alu_res = s9[7:0]; alu_c = s9[8]; alu_ac = s5[4];
      end
      3'd2: alu_res = ~alu_op1;
      3'd3: alu_res = alu_op1 & alu_op2;
      3'd4: alu_res = alu_op1 | alu_op2;
      3'd5: alu_res = ~(alu_op1 & alu_op2);
      3'd6: alu_res = ~(alu_op1 | alu_op2);
      default: alu_res = alu_op1 ^ alu_op2;
    endcase
  end

  // 16-bit reference model.
  function automatic void ref_model(input logic [2:0] op, input logic [15:0] a, b,
                                    output logic [15:0] r, output logic c, ac, ovf,
                                    output int lat);
    int sum;
    c = 1'b0; ac = 1'b0; ovf = 1'b0; lat = 3; r = '0;
    case (op)
      3'd0: begin
        sum = int'(a) + int'(b);
        r   = sum[15:0];
        c   = sum > 65535;
        ac  = (int'(a[3:0]) + int'(b[3:0])) > 15;
        if ((int'(a[7:0]) + int'(b[7:0])) > 255) lat = 4;
        ovf = (a[15] == b[15]) && (r[15] != a[15]);
      end
      3'd1: begin
        r   = a - b;
        c   = a < b;
        ac  = a[3:0] < b[3:0];
        if (a[7:0] < b[7:0]) lat = 4;
        ovf = (a[15] != b[15]) && (r[15] != a[15]);
      end
      3'd2: r = ~a;
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = ~(a & b);
      3'd6: r = ~(a | b);
      default: r = a ^ b;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Issue one command and wait (bounded) for rsp_valid; lat counts edges from accept.
  task automatic issue(input logic [2:0] op, input logic [15:0] a, b, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic run_and_check(input string tag, input logic [2:0] op,
                               input logic [15:0] a, b);
    logic [15:0] er;
    logic ec, eac, eovf;
    int elat, lat;
    ref_model(op, a, b, er, ec, eac, eovf, elat);
    issue(op, a, b, lat);
    check({tag, "_lat"}, 32'(lat), 32'(elat));
    check({tag, "_res"}, 32'(rsp_result), 32'(er));
    check({tag, "_c"}, 32'(rsp_c), 32'(ec));
    check({tag, "_ac"}, 32'(rsp_ac), 32'(eac));
    check({tag, "_z"}, 32'(rsp_z), 32'(er == 16'h0000));
    check({tag, "_s"}, 32'(rsp_s), 32'(er[15]));
`ifdef ALU_SEQ_OVF_EN
    check({tag, "_ovf"}, 32'(rsp_ovf), 32'(eovf));
`endif
    consume();
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a, b, res;
    logic        c, ac, z, s, ovf;
    int          lat;
  } vec_t;

  initial begin
    vec_t vecs[14];
    int lat;
    logic [15:0] held;

    vecs[0]  = '{3'd0, 16'h00FF, 16'h0001, 16'h0100, 0, 1, 0, 0, 0, 4};
    vecs[1]  = '{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1, 1, 1, 0, 0, 4};
    vecs[2]  = '{3'd1, 16'h0100, 16'h0001, 16'h00FF, 0, 1, 0, 0, 0, 4};
    vecs[3]  = '{3'd7, 16'hA5A5, 16'hA5A5, 16'h0000, 0, 0, 1, 0, 0, 3};
    vecs[4]  = '{3'd2, 16'h00F0, 16'h1234, 16'hFF0F, 0, 0, 0, 1, 0, 3};
    vecs[5]  = '{3'd0, 16'h1234, 16'h1111, 16'h2345, 0, 0, 0, 0, 0, 3};
    vecs[6]  = '{3'd3, 16'hF0F0, 16'h3C3C, 16'h3030, 0, 0, 0, 0, 0, 3};
    vecs[7]  = '{3'd4, 16'h8001, 16'h0010, 16'h8011, 0, 0, 0, 1, 0, 3};
    vecs[8]  = '{3'd5, 16'hFFFF, 16'hFFFF, 16'h0000, 0, 0, 1, 0, 0, 3};
    vecs[9]  = '{3'd6, 16'h0000, 16'h0000, 16'hFFFF, 0, 0, 0, 1, 0, 3};
    vecs[10] = '{3'd1, 16'h0000, 16'h0001, 16'hFFFF, 1, 1, 0, 1, 0, 4};
    vecs[11] = '{3'd0, 16'h0008, 16'h0008, 16'h0010, 0, 1, 0, 0, 0, 3};
    vecs[12] = '{3'd0, 16'h7FFF, 16'h0001, 16'h8000, 0, 1, 0, 1, 1, 4};
    vecs[13] = '{3'd1, 16'h8000, 16'h0001, 16'h7FFF, 0, 1, 0, 0, 1, 4};

    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = '0; cmd_a = '0; cmd_b = '0;
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_alu_drive", {13'd0, alu_opcode, alu_op1, alu_op2}, 32'd0);
    check("rst_rsp", {11'd0, rsp_result, rsp_c, rsp_ac, rsp_z, rsp_s}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 14; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_res", i), 32'(rsp_result), 32'(vecs[i].res));
      check($sformatf("vec%0d_flags", i), {28'd0, rsp_c, rsp_ac, rsp_z, rsp_s},
            {28'd0, vecs[i].c, vecs[i].ac, vecs[i].z, vecs[i].s});
`ifdef ALU_SEQ_OVF_EN
      check($sformatf("vec%0d_ovf", i), 32'(rsp_ovf), 32'(vecs[i].ovf));
`endif
      consume();
    end

    // Back-pressure: response held 5 cycles, no new command accepted meanwhile.
    issue(3'd0, 16'h1234, 16'h1111, lat);
    held = rsp_result;
    check("stall_first", 32'(held), 32'h2345);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd7; cmd_a = 16'hFFFF; cmd_b = 16'h0F0F;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("stall%0d_valid", k), 32'(rsp_valid), 32'd1);
      check($sformatf("stall%0d_ready", k), 32'(cmd_ready), 32'd0);
      check($sformatf("stall%0d_res", k), 32'(rsp_result), 32'(held));
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("release_cmd_ready", 32'(cmd_ready), 32'd1);
    check("release_rsp_valid", 32'(rsp_valid), 32'd0);

    // Reset while in FIX (SUB 0x0100-0x0001: fix pass drives opcode 1, op1 1, op2 1).
    @(negedge clk);
    cmd_op = 3'd1; cmd_a = 16'h0100; cmd_b = 16'h0001; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("fix_drive", {13'd0, alu_opcode, alu_op1, alu_op2}, {13'd0, 3'd1, 8'h01, 8'h01});
    rst_n = 1'b0;
    #1;
    check("fixrst_alu_drive", {13'd0, alu_opcode, alu_op1, alu_op2}, 32'd0);
    check("fixrst_rsp", {10'd0, rsp_valid, rsp_result, rsp_c, rsp_ac, rsp_z, rsp_s}, 32'd0);
    check("fixrst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("postrst%0d", k), {30'd0, cmd_ready, rsp_valid}, 32'd2);
    end

    // Randomized against the reference model.
    for (int n = 0; n < 150; n++) begin
      run_and_check($sformatf("rnd%0d", n), 3'($urandom_range(0, 7)),
                    16'($urandom), 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
